// File: rtl/lut_target_writer.sv
// Branch-target table write side.
// A loader writes (index, target) pairs over a valid/ready handshake.
// Fetch reads the table combinationally.
// After reset, and whenever ClearReq is seen in IDLE, the table is swept
// to DEFAULT one entry per cycle.
module lut_target_writer #(
  parameter int unsigned     ENTRIES = 16,
  parameter int unsigned     IDX_W   = 4,
  parameter int unsigned     TW      = 10,
  parameter logic [TW-1:0]   DEFAULT = 10'h001
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             WrValid,
  output logic             WrReady,
  input  logic [IDX_W-1:0] WrIdx,
  input  logic [TW-1:0]    WrTarget,
  input  logic             ClearReq,
  input  logic [IDX_W-1:0] RdAddr,
  output logic [TW-1:0]    RdTarget,
  output logic             Busy,
  output logic             ClearDone,
  output logic [7:0]       WrCount
);

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [7:0]         cnt_q, cnt_d;
  logic               clear_done_q, clear_done_d;

  // The array has no reset; the sweep is what initialises it.
  logic [TW-1:0]      mem_q [ENTRIES];
  logic               mem_we;
  logic [IDX_W-1:0]   mem_waddr;
  logic [TW-1:0]      mem_wdata;

  // Next-state logic: sweep progress, write acceptance, clear priority.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    clear_done_d = 1'b0;
    mem_we       = 1'b0;
    mem_waddr    = idx_q;
    mem_wdata    = DEFAULT;
    case (state_q)
      S_CLEAR: begin
        // ClearReq is deliberately ignored here; the sweep never restarts.
        mem_we    = 1'b1;
        mem_waddr = idx_q;
        mem_wdata = DEFAULT;
        if (idx_q == IDX_W'(ENTRIES - 1)) begin
          state_d      = S_IDLE;
          idx_d        = '0;
          clear_done_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_IDLE: begin
        if (ClearReq) begin
          // The clear wins over a simultaneous write; the loader keeps holding it.
          state_d = S_CLEAR;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (WrValid) begin
          mem_we    = 1'b1;
          mem_waddr = WrIdx;
          mem_wdata = WrTarget;
          if (cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: begin
        state_d = S_CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  // Control state: FSM, sweep index, write counter, done pulse.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_CLEAR;
      idx_q        <= '0;
      cnt_q        <= '0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      clear_done_q <= clear_done_d;
    end
  end

  // Table storage: one write port shared by the sweep and the loader.
  always_ff @(posedge Clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign Busy      = (state_q == S_CLEAR);
  assign WrReady   = (state_q == S_IDLE) && !ClearReq;
  assign ClearDone = clear_done_q;
  assign WrCount   = cnt_q;
  // Reads are masked while busy, so partially swept contents never leak out.
  assign RdTarget  = Busy ? DEFAULT : mem_q[RdAddr];

endmodule

// File: tb/tb_lut_target_writer.sv
// Directed plus randomised bench for lut_target_writer.
// The reference model tracks the table as a plain array.
// A clear is modelled as an instant fill plus a count of busy cycles.
module tb_lut_target_writer;
  localparam int ENTRIES = 16;
  localparam int IDX_W   = 4;
  localparam int TW      = 10;
  localparam logic [TW-1:0] DEF = 10'h001;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             WrValid;
  logic             WrReady;
  logic [IDX_W-1:0] WrIdx;
  logic [TW-1:0]    WrTarget;
  logic             ClearReq;
  logic [IDX_W-1:0] RdAddr;
  logic [TW-1:0]    RdTarget;
  logic             Busy;
  logic             ClearDone;
  logic [7:0]       WrCount;

  lut_target_writer dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .WrValid   (WrValid),
    .WrReady   (WrReady),
    .WrIdx     (WrIdx),
    .WrTarget  (WrTarget),
    .ClearReq  (ClearReq),
    .RdAddr    (RdAddr),
    .RdTarget  (RdTarget),
    .Busy      (Busy),
    .ClearDone (ClearDone),
    .WrCount   (WrCount)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [TW-1:0] m_mem [ENTRIES];
  int            m_sweep;   // sweep cycles completed; busy while < ENTRIES
  int            m_cnt;
  bit            m_done;
  bit            last_acc;

  function automatic bit m_busy();
    return (m_sweep < ENTRIES);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < ENTRIES; i++) m_mem[i] = DEF;
    m_sweep = 0;
    m_cnt   = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic          e_busy;
    logic          e_rdy;
    logic [TW-1:0] e_rd;
    e_busy = m_busy();
    e_rdy  = !e_busy && !ClearReq;
    e_rd   = e_busy ? DEF : m_mem[RdAddr];
    chk({tag, ".busy"},  32'(Busy),      32'(e_busy));
    chk({tag, ".ready"}, 32'(WrReady),   32'(e_rdy));
    chk({tag, ".rd"},    32'(RdTarget),  32'(e_rd));
    chk({tag, ".done"},  32'(ClearDone), 32'(m_done));
    chk({tag, ".cnt"},   32'(WrCount),   32'(m_cnt));
  endtask

  // Advance one clock edge and apply the table rules to the model.
  task automatic tick();
    bit busy_pre;
    busy_pre = m_busy();
    last_acc = 1'b0;
    @(posedge Clk);
    if (!Reset) begin
      if (busy_pre) begin
        m_sweep++;
        m_done = (m_sweep == ENTRIES);
      end else begin
        m_done = 1'b0;
        if (ClearReq) begin
          model_clear();
        end else if (WrValid) begin
          m_mem[WrIdx] = WrTarget;
          if (m_cnt < 255) m_cnt++;
          last_acc = 1'b1;
        end
      end
    end
    #2;
  endtask

  task automatic cyc(input string tag);
    #1;
    check_all(tag);
    tick();
  endtask

  task automatic do_reset(input string tag);
    Reset = 1'b1;
    model_clear();
    m_done = 1'b0;
    #1;
    check_all(tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pend;
    Reset    = 1'b0;
    WrValid  = 1'b0;
    ClearReq = 1'b0;
    WrIdx    = '0;
    WrTarget = '0;
    RdAddr   = '0;
    model_clear();
    m_done   = 1'b0;
    last_acc = 1'b0;
    #3;

    // Post-reset sweep with a write held from the start
    WrValid  = 1'b1;
    WrIdx    = 4'd0;
    WrTarget = 10'h2AA;
    do_reset("rst");
    chk("rst_busy", 32'(Busy), 32'd1);
    chk("rst_rd",   32'(RdTarget), 32'(DEF));
    tick();
    cyc("rst_hold");
    Reset = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      RdAddr = IDX_W'($urandom());
      #1;
      chk("sweep0_busy", 32'(Busy), 32'(k < 16));
      chk("sweep0_done", 32'(ClearDone), 32'(k == 16));
      cyc("sweep0");
    end
    WrValid = 1'b0;

    // Basic write then read-back of every entry
    WrValid = 1'b1; WrIdx = 4'd3; WrTarget = 10'h3FF;
    cyc("wr3");
    WrIdx = 4'd7; WrTarget = 10'h003;
    cyc("wr7");
    WrValid = 1'b0;
    for (int a = 0; a < ENTRIES; a++) begin
      RdAddr = IDX_W'(a);
      #1;
      if (a == 3) chk("basic_rd3", 32'(RdTarget), 32'h3FF);
      if (a == 7) chk("basic_rd7", 32'(RdTarget), 32'h003);
      if (a == 5) chk("basic_rd5", 32'(RdTarget), 32'(DEF));
      cyc("basic");
    end
    chk("basic_cnt", 32'(WrCount), 32'd3);

    // No write-to-read bypass
    RdAddr = 4'd5;
    WrValid = 1'b1; WrIdx = 4'd5; WrTarget = 10'h007;
    #1;
    chk("nobyp_old", 32'(RdTarget), 32'(DEF));
    cyc("nobyp");
    WrValid = 1'b0;
    #1;
    chk("nobyp_new", 32'(RdTarget), 32'h007);
    cyc("nobyp2");

    // Clear takes priority over a simultaneous write
    ClearReq = 1'b1;
    WrValid = 1'b1; WrIdx = 4'd2; WrTarget = 10'h155;
    RdAddr = 4'd3;
    #1;
    chk("clr_ready", 32'(WrReady), 32'd0);
    cyc("clr");
    ClearReq = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      ClearReq = (k == 4 || k == 9);
      #1;
      chk("sweep1_busy", 32'(Busy), 32'(k < 16));
      if (k == 16) begin
        chk("sweep1_cnt",  32'(WrCount), 32'd0);
        chk("sweep1_rd3",  32'(RdTarget), 32'(DEF));
        chk("sweep1_done", 32'(ClearDone), 32'd1);
      end
      cyc("sweep1");
    end
    WrValid = 1'b0;
    RdAddr = 4'd2;
    #1;
    chk("clr_late_wr", 32'(RdTarget), 32'h155);
    cyc("clr_after");

    // Reset in the middle of a sweep
    ClearReq = 1'b1;
    cyc("clr2");
    ClearReq = 1'b0;
    WrValid = 1'b1; WrIdx = 4'd9; WrTarget = 10'h0F0;
    for (int k = 0; k < 9; k++) cyc("sweep2");
    #2;
    WrValid = 1'b0;
    do_reset("midrst");
    chk("midrst_cnt", 32'(WrCount), 32'd0);
    tick();
    cyc("midrst_hold");
    Reset = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      RdAddr = IDX_W'($urandom());
      #1;
      chk("sweep3_busy", 32'(Busy), 32'(k < 16));
      chk("sweep3_done", 32'(ClearDone), 32'(k == 16));
      cyc("sweep3");
    end

    // Saturation: 300 back-to-back writes
    for (int i = 0; i < 300; i++) begin
      WrValid  = 1'b1;
      WrIdx    = IDX_W'($urandom());
      WrTarget = TW'($urandom());
      RdAddr   = IDX_W'($urandom());
      cyc("sat");
    end
    WrValid = 1'b0;
    #1;
    chk("sat_cnt", 32'(WrCount), 32'd255);
    for (int a = 0; a < ENTRIES; a++) begin
      RdAddr = IDX_W'(a);
      cyc("sat_rd");
    end

    // Random traffic with a loader that holds until accepted
    pend = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!pend && $urandom_range(0, 2) != 0) begin
        pend     = 1'b1;
        WrIdx    = IDX_W'($urandom());
        WrTarget = TW'($urandom());
      end
      WrValid  = pend;
      ClearReq = ($urandom_range(0, 40) == 0);
      RdAddr   = IDX_W'($urandom());
      cyc("rand");
      if (last_acc) pend = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
